// File: rtl/sensor_emu_ctl.sv
// Run controller for the sensor-emulator frame generator: start/stop/budget
// sequencing, frame request lines, per-frame pattern stream and frame counters.
module sensor_emu_ctl #(
    parameter int PATTERN_WIDTH = 32,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     stop,
    input  logic [COUNT_WIDTH-1:0]   frame_count,
    input  logic                     use_rs256,
    input  logic [1:0]               pattern_mode,
    input  logic [PATTERN_WIDTH-1:0] pattern_seed,
    output logic                     gen_enable,
    output logic                     rs0,
    output logic                     rs256,
    input  logic                     gen_sof,
    input  logic                     gen_eof,
    output logic [PATTERN_WIDTH-1:0] PATTERN_TDATA,
    output logic                     PATTERN_TVALID,
    input  logic                     PATTERN_TREADY,
    output logic                     busy,
    output logic [COUNT_WIDTH-1:0]   frames_started,
    output logic [COUNT_WIDTH-1:0]   frames_done,
    output logic                     done,
    output logic                     underflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     sof_q, eof_q;
    logic [COUNT_WIDTH-1:0]   budget_q, budget_d;
    logic                     sel_q, sel_d;
    logic [1:0]               mode_q, mode_d;
    logic                     req_q, req_d;
    logic                     active_q, active_d;
    logic [PATTERN_WIDTH-1:0] tdata_q, tdata_d;
    logic [COUNT_WIDTH-1:0]   started_q, started_d;
    logic [COUNT_WIDTH-1:0]   fdone_q, fdone_d;
    logic                     done_q, done_d;
    logic                     underflow_q, underflow_d;

    logic                     sof_rise, eof_fall;
    logic [COUNT_WIDTH-1:0]   started_inc;
    logic [PATTERN_WIDTH-1:0] pat_rot;
    logic [PATTERN_WIDTH-1:0] pat_next;

    assign sof_rise    = gen_sof & ~sof_q;
    assign eof_fall    = ~gen_eof & eof_q;
    assign started_inc = started_q + COUNT_WIDTH'(1);

    // Rotate-left-by-one: MSB wraps into bit 0.
    assign pat_rot[0] = tdata_q[PATTERN_WIDTH-1];
    generate
        for (genvar gi = 1; gi < PATTERN_WIDTH; gi++) begin : g_rot
            assign pat_rot[gi] = tdata_q[gi-1];
        end
    endgenerate

    always_comb begin
        pat_next = tdata_q;
        case (mode_q)
            2'd1:    pat_next = tdata_q + PATTERN_WIDTH'(1);
            2'd2:    pat_next = pat_rot;
            default: pat_next = tdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        budget_d    = budget_q;
        sel_d       = sel_q;
        mode_d      = mode_q;
        req_d       = req_q;
        active_d    = active_q;
        tdata_d     = tdata_q;
        started_d   = started_q;
        fdone_d     = fdone_q;
        done_d      = 1'b0;
        underflow_d = underflow_q | (PATTERN_TREADY & ~active_q);

        if (active_q && PATTERN_TREADY) begin
            tdata_d = pat_next;
        end

        // Frame markers are tracked for the whole run, including the drain.
        if (state_q != ST_IDLE) begin
            if (sof_rise) begin
                started_d = started_inc;
            end
            if (eof_fall) begin
                fdone_d = fdone_q + COUNT_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    budget_d    = frame_count;
                    sel_d       = use_rs256;
                    mode_d      = pattern_mode;
                    tdata_d     = pattern_seed;
                    started_d   = '0;
                    fdone_d     = '0;
                    underflow_d = 1'b0;
                    active_d    = 1'b1;
                    req_d       = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop || (sof_rise && (budget_q != '0) && (started_inc == budget_q))) begin
                    req_d   = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((fdone_q == started_q) && !gen_sof && !gen_eof) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                req_d    = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            budget_q    <= '0;
            sel_q       <= 1'b0;
            mode_q      <= 2'd0;
            req_q       <= 1'b0;
            active_q    <= 1'b0;
            tdata_q     <= '0;
            started_q   <= '0;
            fdone_q     <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sof_q       <= gen_sof;
            eof_q       <= gen_eof;
            budget_q    <= budget_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            req_q       <= req_d;
            active_q    <= active_d;
            tdata_q     <= tdata_d;
            started_q   <= started_d;
            fdone_q     <= fdone_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    assign gen_enable     = active_q;
    assign PATTERN_TVALID = active_q;
    assign busy           = active_q;
    assign rs0            = req_q & ~sel_q;
    assign rs256          = req_q & sel_q;
    assign PATTERN_TDATA  = tdata_q;
    assign frames_started = started_q;
    assign frames_done    = fdone_q;
    assign done           = done_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_sensor_emu_ctl.sv
// Bench for sensor_emu_ctl: a behavioural frame generator drives sof/eof/TREADY,
// and each run is compared with frame counts and pattern sequences from a model.
module tb_sensor_emu_ctl;
    localparam int PW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          stop;
    logic [CW-1:0] frame_count;
    logic          use_rs256;
    logic [1:0]    pattern_mode;
    logic [PW-1:0] pattern_seed;
    logic          gen_enable, rs0, rs256;
    logic          gen_sof, gen_eof;
    logic [PW-1:0] PATTERN_TDATA;
    logic          PATTERN_TVALID;
    logic          PATTERN_TREADY;
    logic          busy;
    logic [CW-1:0] frames_started, frames_done;
    logic          done, underflow;

    always #5 clk = ~clk;

    sensor_emu_ctl #(.PATTERN_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .frame_count(frame_count), .use_rs256(use_rs256),
        .pattern_mode(pattern_mode), .pattern_seed(pattern_seed),
        .gen_enable(gen_enable), .rs0(rs0), .rs256(rs256),
        .gen_sof(gen_sof), .gen_eof(gen_eof),
        .PATTERN_TDATA(PATTERN_TDATA), .PATTERN_TVALID(PATTERN_TVALID),
        .PATTERN_TREADY(PATTERN_TREADY), .busy(busy),
        .frames_started(frames_started), .frames_done(frames_done),
        .done(done), .underflow(underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Generator model state and command mailboxes
    int            gen_total  = 0;
    bit            gen_busy   = 0;
    int            dlen       = 14;
    int            stop_cmd   = 0;   // 1 now, 2 with next sof rise, 3 in data of stop_frame
    int            stop_frame = 0;
    bit            tready_cmd = 0;
    logic [PW-1:0] pat_q[$];
    time           eof_fall_t = 0;

    task automatic step(input logic s, input logic e, input logic r, input bit in_data);
        bit fire;
        @(negedge clk);
        fire = 1'b0;
        if (stop_cmd == 1) fire = 1'b1;
        else if (stop_cmd == 2 && s && !gen_sof) fire = 1'b1;
        else if (stop_cmd == 3 && in_data && (gen_total + 1 == stop_frame)) fire = 1'b1;
        if (fire) stop_cmd = 0;
        stop = fire;
        if (!e && gen_eof) eof_fall_t = $time;
        gen_sof = s;
        gen_eof = e;
        PATTERN_TREADY = r;
        if (r) pat_q.push_back(PATTERN_TDATA);
    endtask

    // Frame = 4 header + dlen data + 3 footer + 2 idle cycles (>= 21 cycles).
    initial begin
        bit r;
        gen_sof = 1'b0; gen_eof = 1'b0; PATTERN_TREADY = 1'b0; stop = 1'b0;
        forever begin
            if (resetn === 1'b1 && gen_enable && (rs0 || rs256)) begin
                gen_busy = 1;
                repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < dlen; i++) step(1'b0, 1'b0, (i == 2), 1'b1);
                repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b0, 1'b0, 1'b0);
                gen_total++;
                step(1'b0, 1'b0, 1'b0, 1'b0);
                gen_busy = 0;
            end else begin
                r = tready_cmd;
                step(1'b0, 1'b0, r, 1'b0);
                if (r) tready_cmd = 0;
            end
        end
    end

    int  rs0_cyc = 0, rs256_cyc = 0, both_cyc = 0, done_cnt = 0;
    time done_t = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rs0) rs0_cyc++;
            if (rs256) rs256_cyc++;
            if (rs0 && rs256) both_cyc++;
            if (done) begin
                done_cnt++;
                done_t = $time;
            end
        end
    end

    function automatic logic [PW-1:0] model_next(input logic [PW-1:0] p, input int m);
        case (m)
            1:       return p + 1;
            2:       return (p << 1) | (p >> (PW - 1));
            default: return p;
        endcase
    endfunction

    task automatic wait_gen_idle();
        int i;
        for (i = 0; i < 300 && gen_busy; i++) @(negedge clk);
        if (gen_busy) check_eq("gen_idle_timeout", 64'(gen_busy), 64'd0);
    endtask

    task automatic wait_total(input string nm, input int target);
        int i;
        for (i = 0; i < 3000 && gen_total < target; i++) @(negedge clk);
        if (gen_total < target) check_eq({nm, ".wait"}, 64'(gen_total), 64'(target));
    endtask

    // smode: 0 budget only, 2 stop with 3rd sof rise, 3 stop in frame 5 data
    task automatic run_test(input string nm, input int budget, input bit sel, input int mode,
                            input logic [PW-1:0] seed, input int smode, input int exp_n,
                            input bit poke);
        int b0, r0, r2, bh, d0, dl, k;
        bit got_done;
        logic [PW-1:0] p;
        wait_gen_idle();
        @(negedge clk);
        b0 = gen_total; r0 = rs0_cyc; r2 = rs256_cyc; bh = both_cyc; d0 = done_cnt;
        pat_q.delete();
        dlen = $urandom_range(12, 20);
        frame_count = budget; use_rs256 = sel; pattern_mode = 2'(mode); pattern_seed = seed;
        start = 1'b1;
        if (smode == 3) begin
            stop_frame = b0 + 5;
            stop_cmd   = 3;
        end
        @(negedge clk);
        start = 1'b0;
        check_eq({nm, ".busy_on"}, 64'(busy), 64'd1);
        check_eq({nm, ".tvalid_on"}, 64'(PATTERN_TVALID), 64'd1);
        check_eq({nm, ".underflow_clr"}, 64'(underflow), 64'd0);
        if (smode == 2) begin
            wait_total(nm, b0 + 2);
            stop_cmd = 2;
        end
        if (poke) begin
            wait_total(nm, b0 + 1);
            @(negedge clk);
            frame_count = 1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got_done = 1'b0;
        for (int i = 0; i < 4000 && !got_done; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        check_eq({nm, ".done_seen"}, 64'(got_done), 64'd1);
        check_eq({nm, ".frames_started"}, 64'(frames_started), 64'(exp_n));
        check_eq({nm, ".frames_done"}, 64'(frames_done), 64'(exp_n));
        check_eq({nm, ".busy_off"}, 64'(busy), 64'd0);
        dl = int'((done_t - eof_fall_t) / 10);
        check_eq({nm, ".done_lat_1to2"}, 64'((dl >= 1) && (dl <= 2)), 64'd1);
        repeat (3) @(negedge clk);
        check_eq({nm, ".gen_frames"}, 64'(gen_total - b0), 64'(exp_n));
        check_eq({nm, ".done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check_eq({nm, ".hold_started"}, 64'(frames_started), 64'(exp_n));
        check_eq({nm, ".both_lines"}, 64'(both_cyc - bh), 64'd0);
        if (sel) begin
            check_eq({nm, ".rs0_unused"}, 64'(rs0_cyc - r0), 64'd0);
            check_eq({nm, ".rs256_used"}, 64'((rs256_cyc - r2) > 0), 64'd1);
        end else begin
            check_eq({nm, ".rs256_unused"}, 64'(rs256_cyc - r2), 64'd0);
            check_eq({nm, ".rs0_used"}, 64'((rs0_cyc - r0) > 0), 64'd1);
        end
        check_eq({nm, ".n_patterns"}, 64'(pat_q.size()), 64'(exp_n));
        p = seed;
        for (k = 0; k < exp_n && k < pat_q.size(); k++) begin
            check_eq($sformatf("%s.pat%0d", nm, k), 64'(pat_q[k]), 64'(p));
            p = model_next(p, mode);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; frame_count = '0; use_rs256 = 1'b0;
        pattern_mode = 2'd0; pattern_seed = '0;
        repeat (3) @(negedge clk);
        check_eq("reset.busy", 64'(busy), 64'd0);
        check_eq("reset.gen_enable", 64'(gen_enable), 64'd0);
        check_eq("reset.rs_lines", 64'({rs0, rs256}), 64'd0);
        check_eq("reset.tdata", 64'(PATTERN_TDATA), 64'd0);
        check_eq("reset.counters", 64'({frames_started, frames_done}), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_test("budget3", 3, 1'b0, 0, $urandom, 0, 3, 1'b0);
        stop_cmd = 1;
        repeat (4) @(negedge clk);
        check_eq("idle_stop.busy", 64'(busy), 64'd0);
        check_eq("idle_stop.started", 64'(frames_started), 64'd3);

        run_test("incr", 3, 1'b1, 1, 32'hFFFF_FFFE, 0, 3, 1'b0);
        run_test("rot", 2, 1'b0, 2, 32'h8000_0001, 0, 2, 1'b0);
        run_test("early_stop", 0, $urandom_range(0, 1), 1, $urandom, 3, 5, 1'b0);
        run_test("stop_on_sof", 0, 1'b1, 2, $urandom, 2, 3, 1'b0);
        run_test("start_busy", 2, 1'b0, 1, $urandom, 0, 2, 1'b1);

        for (int r = 0; r < 4; r++) begin
            int b;
            b = $urandom_range(1, 4);
            run_test($sformatf("rnd%0d", r), b, $urandom_range(0, 1), $urandom_range(0, 3),
                     $urandom, 0, b, 1'b0);
        end

        // Async reset mid-frame, between clock edges
        wait_gen_idle();
        @(negedge clk);
        frame_count = 0; use_rs256 = 1'b0; pattern_mode = 2'd1; pattern_seed = 32'h1234_5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        begin
            int d0;
            d0 = done_cnt;
            #2 resetn = 1'b0;
            #1;
            check_eq("arst.busy", 64'(busy), 64'd0);
            check_eq("arst.enable_valid", 64'({gen_enable, PATTERN_TVALID}), 64'd0);
            check_eq("arst.rs_lines", 64'({rs0, rs256}), 64'd0);
            check_eq("arst.tdata", 64'(PATTERN_TDATA), 64'd0);
            check_eq("arst.counters", 64'({frames_started, frames_done}), 64'd0);
            repeat (3) @(negedge clk);
            resetn = 1'b1;
            repeat (40) @(negedge clk);
            check_eq("arst.no_done", 64'(done_cnt - d0), 64'd0);
            check_eq("arst.idle", 64'(busy), 64'd0);
        end

        // Underflow in IDLE, cleared by next start
        wait_gen_idle();
        tready_cmd = 1;
        repeat (5) @(negedge clk);
        check_eq("underflow.set", 64'(underflow), 64'd1);
        run_test("after_uflow", 1, 1'b0, 0, $urandom, 0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
